ula_181_serial: RTL and testbench

Parametrised, nibble-serial successor of the 4-bit 74181-style ALU. It accepts one WIDTH-bit operation through a valid/ready handshake and evaluates it one 4-bit slice per clock, least significant slice first. The carry ripples through an internal register between slices. The full result and its flags are held in an output register until they are consumed, so the block can sit between a register file and a writeback stage without a WIDTH-bit combinational carry chain.

---
 rtl/ula_181_serial_if.sv | 35 +++
 rtl/ula_181_serial.sv | 153 +++++++++++++++
 tb/tb_ula_181_serial.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_181_serial_if.sv
`default_nettype none
// ============================================================================
//  Module   : ula_181_serial_if
//  Brief    : Handshake and operand/result bundle for the nibble-serial ALU.
//  Revision : 1.0
// ============================================================================
interface ula_181_serial_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       s;
   logic             m;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] f;
   logic             c_out;
   logic             ovf;
   logic             zero;
   logic             a_eq_b;

   modport master (
      output in_valid, a, b, s, m, c_in, out_ready,
      input  in_ready, out_valid, f, c_out, ovf, zero, a_eq_b
   );

   modport slave (
      input  in_valid, a, b, s, m, c_in, out_ready,
      output in_ready, out_valid, f, c_out, ovf, zero, a_eq_b
   );
endinterface
`default_nettype wire

// File: rtl/ula_181_serial.sv
`default_nettype none
// ============================================================================
//  Module   : ula_181_serial
//  Brief    : 74181-style ALU evaluated one 4-bit slice per clock, LS first.
//  Revision : 1.0
// ============================================================================
module ula_181_serial #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   ula_181_serial_if.slave  bus
);
   localparam int SLICES = WIDTH / 4;
   localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [CW-1:0] c_LAST = CW'(SLICES - 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   logic [1:0]       state_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q, f_q, f_d;
   logic [3:0]       s_q;
   logic             m_q;
   logic             c_out_q, ovf_q, zero_q, a_eq_b_q;

   logic [3:0]       w_a, w_b, w_x, w_y, w_lg, w_res;
   logic [4:0]       w_sum;
   logic             w_c3;

   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int k = 0; k < SLICES; k++) begin
         if (cnt_q == CW'(k)) begin
            w_a = a_q[4*k +: 4];
            w_b = b_q[4*k +: 4];
         end
      end

      case (s_q)
         4'b0000: w_lg = ~w_a;
         4'b0001: w_lg = ~(w_a | w_b);
         4'b0010: w_lg = ~w_a & w_b;
         4'b0011: w_lg = 4'h0;
         4'b0100: w_lg = ~(w_a & w_b);
         4'b0101: w_lg = ~w_b;
         4'b0110: w_lg = w_a ^ w_b;
         4'b0111: w_lg = w_a & ~w_b;
         4'b1000: w_lg = ~w_a | w_b;
         4'b1001: w_lg = ~(w_a ^ w_b);
         4'b1010: w_lg = w_b;
         4'b1011: w_lg = w_a & w_b;
         4'b1100: w_lg = 4'hF;
         4'b1101: w_lg = w_a | ~w_b;
         4'b1110: w_lg = w_a | w_b;
         default: w_lg = w_a;
      endcase

      // Arithmetic mode: slice result is X + Y + carry with X/Y picked by S.
      case (s_q)
         4'b0000: begin w_x = w_a;          w_y = 4'h0;          end
         4'b0001: begin w_x = w_a | w_b;    w_y = 4'h0;          end
         4'b0010: begin w_x = w_a | ~w_b;   w_y = 4'h0;          end
         4'b0011: begin w_x = 4'hF;         w_y = 4'h0;          end
         4'b0100: begin w_x = w_a;          w_y = w_a & ~w_b;    end
         4'b0101: begin w_x = w_a | w_b;    w_y = w_a & ~w_b;    end
         4'b0110: begin w_x = w_a;          w_y = ~w_b;          end
         4'b0111: begin w_x = w_a & ~w_b;   w_y = 4'hF;          end
         4'b1000: begin w_x = w_a;          w_y = w_a;           end
         4'b1001: begin w_x = w_a;          w_y = w_a | w_b;     end
         4'b1010: begin w_x = w_a;          w_y = w_a | ~w_b;    end
         4'b1011: begin w_x = w_a;          w_y = 4'hF;          end
         4'b1100: begin w_x = w_a;          w_y = w_a & w_b;     end
         4'b1101: begin w_x = w_a | w_b;    w_y = w_a & w_b;     end
         4'b1110: begin w_x = w_a | ~w_b;   w_y = w_a & w_b;     end
         default: begin w_x = w_a;          w_y = 4'h0;          end
      endcase

      w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, carry_q};
      w_c3  = w_x[3] ^ w_y[3] ^ w_sum[3];
      w_res = m_q ? w_lg : w_sum[3:0];

      f_d = f_q;
      for (int k = 0; k < SLICES; k++) begin
         if (cnt_q == CW'(k)) begin
            f_d[4*k +: 4] = w_res;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= c_IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= 4'h0;
         m_q      <= 1'b0;
         f_q      <= '0;
         c_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         a_eq_b_q <= 1'b0;
      end else begin
         case (state_q)
            c_IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  s_q     <= bus.s;
                  m_q     <= bus.m;
                  carry_q <= bus.c_in;
                  cnt_q   <= '0;
                  state_q <= c_RUN;
               end
            end
            c_RUN: begin
               f_q     <= f_d;
               carry_q <= w_sum[4];
               cnt_q   <= cnt_q + 1'b1;
               // Flags are captured together with the final slice.
               if (cnt_q == c_LAST) begin
                  state_q  <= c_DONE;
                  c_out_q  <= m_q ? 1'b0 : w_sum[4];
                  ovf_q    <= m_q ? 1'b0 : (w_c3 ^ w_sum[4]);
                  zero_q   <= (f_d == '0);
                  a_eq_b_q <= (a_q == b_q);
               end
            end
            c_DONE: begin
               if (bus.out_ready) begin
                  state_q <= c_IDLE;
               end
            end
            default: state_q <= c_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == c_IDLE) & ~rst;
   assign bus.out_valid = (state_q == c_DONE);
   assign bus.f         = f_q;
   assign bus.c_out     = c_out_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
   assign bus.a_eq_b    = a_eq_b_q;
endmodule
`default_nettype wire

// File: tb/tb_ula_181_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ula_181_serial
//  Brief    : Bench for ula_181_serial at WIDTH=16 and WIDTH=4 against a word-level model.
//  Revision : 1.0
// ============================================================================
module tb_ula_181_serial;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ula_181_serial_if #(.WIDTH(16)) bus16 ();
   ula_181_serial_if #(.WIDTH(4))  bus4  ();

   ula_181_serial #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
   ula_181_serial #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

   // Index 0 drives/observes the 16-bit instance, index 1 the 4-bit one.
   logic        dv[2], dm[2], dc[2], dordy[2];
   logic [15:0] da[2], db[2];
   logic [3:0]  ds[2];
   logic        mrdy[2], mval[2];
   logic [19:0] mout[2];

   assign bus16.in_valid  = dv[0];
   assign bus16.a         = da[0];
   assign bus16.b         = db[0];
   assign bus16.s         = ds[0];
   assign bus16.m         = dm[0];
   assign bus16.c_in      = dc[0];
   assign bus16.out_ready = dordy[0];
   assign bus4.in_valid   = dv[1];
   assign bus4.a          = da[1][3:0];
   assign bus4.b          = db[1][3:0];
   assign bus4.s          = ds[1];
   assign bus4.m          = dm[1];
   assign bus4.c_in       = dc[1];
   assign bus4.out_ready  = dordy[1];

   assign mrdy[0] = bus16.in_ready;
   assign mval[0] = bus16.out_valid;
   assign mout[0] = {bus16.a_eq_b, bus16.zero, bus16.ovf, bus16.c_out, bus16.f};
   assign mrdy[1] = bus4.in_ready;
   assign mval[1] = bus4.out_valid;
   assign mout[1] = {bus4.a_eq_b, bus4.zero, bus4.ovf, bus4.c_out, 12'h000, bus4.f};

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic int wid(input int d);
      return (d == 0) ? 16 : 4;
   endfunction

   function automatic int slices(input int d);
      return wid(d) / 4;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Whole-word reference: {a_eq_b, zero, ovf, c_out, f}.
   function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] s, input logic m, input logic c,
                                         input int w);
      logic [31:0] mk, A, B, X, Y, L, sum, t, lo;
      logic [15:0] f;
      logic        cout, ovf;
      mk = (32'h1 << w) - 32'h1;
      A  = {16'h0, a} & mk;
      B  = {16'h0, b} & mk;
      case (s)
         4'h0: L = ~A;       4'h1: L = ~(A | B);  4'h2: L = ~A & B;  4'h3: L = 32'h0;
         4'h4: L = ~(A & B); 4'h5: L = ~B;        4'h6: L = A ^ B;   4'h7: L = A & ~B;
         4'h8: L = ~A | B;   4'h9: L = ~(A ^ B);  4'hA: L = B;       4'hB: L = A & B;
         4'hC: L = ~32'h0;   4'hD: L = A | ~B;    4'hE: L = A | B;   default: L = A;
      endcase
      case (s)
         4'h0: begin X = A;      Y = 32'h0;   end
         4'h1: begin X = A | B;  Y = 32'h0;   end
         4'h2: begin X = A | ~B; Y = 32'h0;   end
         4'h3: begin X = ~32'h0; Y = 32'h0;   end
         4'h4: begin X = A;      Y = A & ~B;  end
         4'h5: begin X = A | B;  Y = A & ~B;  end
         4'h6: begin X = A;      Y = ~B;      end
         4'h7: begin X = A & ~B; Y = ~32'h0;  end
         4'h8: begin X = A;      Y = A;       end
         4'h9: begin X = A;      Y = A | B;   end
         4'hA: begin X = A;      Y = A | ~B;  end
         4'hB: begin X = A;      Y = ~32'h0;  end
         4'hC: begin X = A;      Y = A & B;   end
         4'hD: begin X = A | B;  Y = A & B;   end
         4'hE: begin X = A | ~B; Y = A & B;   end
         default: begin X = A;   Y = 32'h0;   end
      endcase
      L   = L & mk;
      X   = X & mk;
      Y   = Y & mk;
      sum = X + Y + {31'h0, c};
      t   = sum >> w;
      lo  = ((X & (mk >> 1)) + (Y & (mk >> 1)) + {31'h0, c}) >> (w - 1);
      if (m) begin
         f = L[15:0]; cout = 1'b0; ovf = 1'b0;
      end else begin
         f = sum[15:0] & mk[15:0]; cout = t[0]; ovf = lo[0] ^ t[0];
      end
      return {(A == B), (f == 16'h0), ovf, cout, f};
   endfunction

   // Compare process: tracks each instance's expected occupancy and result.
   logic        busy[2], seen[2];
   logic [19:0] expv[2];
   int          acc[2];

   initial begin
      for (int d = 0; d < 2; d++) begin
         busy[d] = 1'b0; seen[d] = 1'b0; expv[d] = '0; acc[d] = 0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rst) begin
               chk("in_ready_during_rst", {31'h0, mrdy[d]}, 32'h0);
               busy[d] = 1'b0;
               seen[d] = 1'b0;
            end else begin
               chk("in_ready", {31'h0, mrdy[d]}, {31'h0, !busy[d]});
               if (!busy[d]) begin
                  chk("out_valid_idle", {31'h0, mval[d]}, 32'h0);
               end else if (mval[d]) begin
                  if (!seen[d]) begin
                     chk("latency", cyc - acc[d], slices(d));
                     seen[d] = 1'b1;
                  end
                  chk("result", {12'h0, mout[d]}, {12'h0, expv[d]});
               end else if (seen[d] || (cyc - acc[d] >= slices(d))) begin
                  chk("out_valid_busy", {31'h0, mval[d]}, 32'h1);
               end
               if (busy[d] && mval[d] && dordy[d]) begin
                  busy[d] = 1'b0;
                  seen[d] = 1'b0;
               end else if (!busy[d] && dv[d]) begin
                  busy[d] = 1'b1;
                  seen[d] = 1'b0;
                  expv[d] = model(da[d], db[d], ds[d], dm[d], dc[d], wid(d));
                  acc[d]  = cyc + 1;
               end
            end
         end
      end
   end

   task automatic do_op(input int d, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] s, input logic m, input logic c,
                        input int hold, output logic [19:0] got);
      int n;
      @(posedge clk); #1;
      dv[d] = 1'b1; da[d] = a; db[d] = b; ds[d] = s; dm[d] = m; dc[d] = c;
      n = 0;
      do begin @(negedge clk); n++; end while (!mrdy[d] && n < 40);
      if (!mrdy[d]) chk("accept_timeout", {31'h0, mrdy[d]}, 32'h1);
      @(posedge clk); #1;
      dv[d] = 1'b0;
      da[d] = 16'($urandom); db[d] = 16'($urandom); ds[d] = 4'($urandom);
      dm[d] = 1'($urandom);  dc[d] = 1'($urandom);
      n = 0;
      do begin @(negedge clk); n++; end while (!mval[d] && n < 40);
      if (!mval[d]) chk("valid_timeout", {31'h0, mval[d]}, 32'h1);
      got = mout[d];
      repeat (hold) @(posedge clk);
      @(posedge clk); #1 dordy[d] = 1'b1;
      @(posedge clk); #1 dordy[d] = 1'b0;
   endtask

   task automatic lit(input string nm, input int d, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] s, input logic m, input logic c, input logic [19:0] want);
      logic [19:0] got;
      chk({nm, "_model"}, {12'h0, model(a, b, s, m, c, wid(d))}, {12'h0, want});
      do_op(d, a, b, s, m, c, 0, got);
      chk(nm, {12'h0, got}, {12'h0, want});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] got, want;
      logic [15:0] a, b, na, nb;
      logic [3:0]  s;
      logic        m, c;
      int          d, n;

      for (int i = 0; i < 2; i++) begin
         dv[i] = 1'b0; dm[i] = 1'b0; dc[i] = 1'b0; dordy[i] = 1'b0;
         da[i] = 16'h0; db[i] = 16'h0; ds[i] = 4'h0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("reset_state", {11'h0, mval[i], mout[i]}, 32'h0);
      @(posedge clk); #1 rst = 1'b0;

      // Hand-computed results; each pins both the model and the DUT.
      lit("add_ovf16",   0, 16'h7FFF, 16'h0001, 4'b1101, 1'b0, 1'b0, 20'h2_8000);
      lit("sub_5m7",     0, 16'h0005, 16'h0007, 4'b0110, 1'b0, 1'b1, 20'h0_FFFE);
      lit("sub_7m5",     0, 16'h0007, 16'h0005, 4'b0110, 1'b0, 1'b1, 20'h1_0002);
      lit("xor_equal",   0, 16'hA5A5, 16'hA5A5, 4'b0110, 1'b1, 1'b0, 20'hC_0000);
      lit("chain16_c0",  0, 16'h1234, 16'h5678, 4'b0011, 1'b0, 1'b0, 20'h0_FFFF);
      lit("chain16_c1",  0, 16'h1234, 16'h5678, 4'b0011, 1'b0, 1'b1, 20'h5_0000);
      lit("chain4_c0",   1, 16'h0003, 16'h0009, 4'b0011, 1'b0, 1'b0, 20'h0_000F);
      lit("chain4_c1",   1, 16'h0003, 16'h0009, 4'b0011, 1'b0, 1'b1, 20'h5_0000);
      lit("add_ovf4",    1, 16'h0007, 16'h0001, 4'b1101, 1'b0, 1'b0, 20'h2_0008);

      // Backpressure: result held for 10 cycles while a new request waits.
      a = 16'h1234; b = 16'h0F0F; na = 16'hBEEF; nb = 16'h0101;
      want = model(a, b, 4'b1001, 1'b0, 1'b1, 16);
      @(posedge clk); #1;
      dv[0] = 1'b1; da[0] = a; db[0] = b; ds[0] = 4'b1001; dm[0] = 1'b0; dc[0] = 1'b1;
      @(negedge clk);
      chk("bp_accept_ready", {31'h0, mrdy[0]}, 32'h1);
      @(posedge clk); #1;
      da[0] = na; db[0] = nb; ds[0] = 4'b1101; dc[0] = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!mval[0] && n < 40);
      for (int k = 0; k < 10; k++) begin
         chk("bp_valid", {31'h0, mval[0]}, 32'h1);
         chk("bp_ready", {31'h0, mrdy[0]}, 32'h0);
         chk("bp_hold",  {12'h0, mout[0]}, {12'h0, want});
         @(negedge clk);
      end
      @(posedge clk); #1 dordy[0] = 1'b1;
      @(posedge clk); #1 dordy[0] = 1'b0;
      @(negedge clk);
      chk("bp_idle_ready", {31'h0, mrdy[0]}, 32'h1);
      chk("bp_idle_valid", {31'h0, mval[0]}, 32'h0);
      @(posedge clk); #1 dv[0] = 1'b0;
      want = model(na, nb, 4'b1101, 1'b0, 1'b0, 16);
      n = 0;
      do begin @(negedge clk); n++; end while (!mval[0] && n < 40);
      chk("bp_pending_result", {11'h0, mval[0], mout[0]}, {11'h0, 1'b1, want});
      @(posedge clk); #1 dordy[0] = 1'b1;
      @(posedge clk); #1 dordy[0] = 1'b0;

      // Reset asserted during the second RUN cycle aborts the operation.
      @(posedge clk); #1;
      dv[0] = 1'b1; da[0] = 16'hFFFF; db[0] = 16'h0001; ds[0] = 4'b1001; dm[0] = 1'b0; dc[0] = 1'b0;
      @(negedge clk);
      chk("rst_op_ready", {31'h0, mrdy[0]}, 32'h1);
      @(posedge clk); #1 dv[0] = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_mid_out",   {11'h0, mval[i], mout[i]}, 32'h0);
         chk("rst_mid_ready", {31'h0, mrdy[i]}, 32'h0);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_release_ready", {31'h0, mrdy[0]}, 32'h1);
      repeat (8) @(negedge clk);
      chk("rst_no_valid", {31'h0, mval[0]}, 32'h0);

      // Randomized operations on both widths.
      for (int i = 0; i < 150; i++) begin
         d = (i % 3 == 0) ? 1 : 0;
         a = 16'($urandom);
         b = 16'($urandom);
         if (d == 1) begin a = a & 16'h000F; b = b & 16'h000F; end
         if ($urandom_range(0, 7) == 0) b = a;
         s = 4'($urandom);
         m = 1'($urandom);
         c = 1'($urandom);
         want = model(a, b, s, m, c, wid(d));
         do_op(d, a, b, s, m, c, $urandom_range(0, 3), got);
         chk("random_result", {12'h0, got}, {12'h0, want});
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
